// File: rtl/time_counter_display.sv
// -----------------------------------------------------------------------------
// time_counter_display
//
// Purpose:
//   Seconds / mm:ss / hh:mm:ss BCD time counter driven by a 1 s tick derived
//   from clk. Counts up with wrap, or down with a stop at zero (timer mode).
//   It also scans the digits onto one shared 7-segment bus with an active-low
//   common line for each digit.
//
// Parameters:
//   CLK_HZ_DIV  clk cycles per 1 s tick (>= 2)
//   SCAN_DIV    clk cycles per digit scan slot (>= 1)
//   N_DIGITS    2 = ss, 4 = mm:ss, 6 = hh:mm:ss (only these values are legal)
//   COUNT_DOWN  0 = count up with wrap, 1 = count down and stop at zero
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous reset, active-high
//   run       in   1 = prescaler advances; 0 = prescaler and time frozen
//   clear     in   synchronous: time := 0, prescaler := 0 (highest priority)
//   load      in   synchronous: time := load_bcd, prescaler := 0
//   load_bcd  in   BCD preset; digit 0 (seconds ones) is in bits [3:0]
//   time_bcd  out  current BCD time, packed the same way as load_bcd
//   wrap      out  1-cycle pulse when an up-count rolls from max to all zero
//   done      out  down mode only: high while time is zero and stopped
//   seg_com   out  digit enables, active-low; digit k drives bit 7-k
//   seg_data  out  segments {a,b,c,d,e,f,g,dp}, active-high
// -----------------------------------------------------------------------------
module time_counter_display #(
    parameter int CLK_HZ_DIV = 1000,
    parameter int SCAN_DIV   = 1,
    parameter int N_DIGITS   = 4,
    parameter int COUNT_DOWN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_bcd,
    output logic [4*N_DIGITS-1:0] time_bcd,
    output logic                  wrap,
    output logic                  done,
    output logic [7:0]            seg_com,
    output logic [7:0]            seg_data
);

    localparam int W        = 4 * N_DIGITS;
    localparam int N_FIELDS = N_DIGITS / 2;
    localparam int PRE_W    = $clog2(CLK_HZ_DIV);
    localparam int SLOT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = $clog2(N_DIGITS);
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_HZ_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(N_DIGITS - 1);
    localparam bit DOWN = (COUNT_DOWN != 0);

    // Increment one two-digit field. Result is {carry_out, new_field}.
    // Field 2 is hours (00..23); all others are 00..59.
    function automatic logic [8:0] field_inc(input logic [7:0] v, input logic is_hour);
        logic [8:0] r;
        if (is_hour ? (v == 8'h23) : (v == 8'h59))
            r = 9'h100;
        else if (v[3:0] == 4'd9)
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Decrement one two-digit field. Result is {borrow_out, new_field}.
    function automatic logic [8:0] field_dec(input logic [7:0] v, input logic is_hour);
        logic [8:0] r;
        if (v == 8'h00)
            r = {1'b1, (is_hour ? 8'h23 : 8'h59)};
        else if (v[3:0] == 4'd0)
            r = {1'b0, v[7:4] - 4'd1, 4'd9};
        else
            r = {1'b0, v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hFC;
            4'd1:    s = 8'h60;
            4'd2:    s = 8'hDA;
            4'd3:    s = 8'hF2;
            4'd4:    s = 8'h66;
            4'd5:    s = 8'hB6;
            4'd6:    s = 8'hBE;
            4'd7:    s = 8'hE4;
            4'd8:    s = 8'hFE;
            4'd9:    s = 8'hF6;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- time path
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] nxt_pre;
    logic [W-1:0]     up_time;
    logic [W-1:0]     dn_time;
    logic [W-1:0]     nxt_time;
    logic             up_wrap;
    logic             nxt_wrap;
    logic             tick;
    logic             time_zero;

    assign tick      = run && (pre == PRE_MAX);
    assign time_zero = (time_bcd == '0);

    // Both the incremented and decremented time are formed every cycle; the
    // carry/borrow ripples through all fields within the same edge.
    always_comb begin : time_math
        logic       carry;
        logic       borrow;
        logic [8:0] r;
        up_time = time_bcd;
        dn_time = time_bcd;
        carry   = 1'b1;
        borrow  = 1'b1;
        r       = '0;
        for (int f = 0; f < N_FIELDS; f++) begin
            if (carry) begin
                r = field_inc(time_bcd[8*f +: 8], f == 2);
                up_time[8*f +: 8] = r[7:0];
                carry = r[8];
            end
            if (borrow) begin
                r = field_dec(time_bcd[8*f +: 8], f == 2);
                dn_time[8*f +: 8] = r[7:0];
                borrow = r[8];
            end
        end
        up_wrap = carry;
    end

    always_comb begin : time_next
        nxt_time = time_bcd;
        nxt_pre  = pre;
        nxt_wrap = 1'b0;
        if (clear) begin
            nxt_time = '0;
            nxt_pre  = '0;
        end else if (load) begin
            nxt_time = load_bcd;
            nxt_pre  = '0;
        end else if (tick) begin
            nxt_pre = '0;
            if (DOWN) begin
                // A timer sitting at zero ignores further ticks.
                if (!time_zero)
                    nxt_time = dn_time;
            end else begin
                nxt_time = up_time;
                nxt_wrap = up_wrap;
            end
        end else if (run) begin
            nxt_pre = pre + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_bcd <= '0;
            pre      <= '0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            time_bcd <= nxt_time;
            pre      <= nxt_pre;
            wrap     <= nxt_wrap;
            done     <= DOWN && (nxt_time == '0);
        end
    end

    // ---------------------------------------------------------------- scan path
    logic [SLOT_W-1:0] slot;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        digit;
    logic              dp;

    always_comb begin
        digit = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (int'(idx) == k)
                digit = time_bcd[4*k +: 4];
        end
    end

    // Decimal points mark the ss|mm and mm|hh separators.
    assign dp = (int'(idx) == 2) || (int'(idx) == 4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot     <= '0;
            idx      <= '0;
            seg_com  <= 8'hFF;
            seg_data <= 8'h00;
        end else begin
            // Outputs reflect the index and time from before this edge.
            seg_com  <= ~(8'h80 >> idx);
            seg_data <= seg_code(digit) | {7'd0, dp};
            if (slot == SLOT_MAX) begin
                slot <= '0;
                idx  <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                slot <= slot + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_counter_display.sv
// -----------------------------------------------------------------------------
// tb_time_counter_display
//
// Drives two instances from shared stimulus: an up-counting mm:ss display and
// a down-counting hh:mm:ss timer, both with a 4-clk second and a 1-clk scan
// slot. A reference model keeps time as a plain number of seconds and pushes
// the expected outputs of every clock edge into a queue; a monitor on the
// falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_time_counter_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_bcd = '0;

    logic [15:0] up_time;
    logic        up_wrap, up_done;
    logic [7:0]  up_com, up_data;
    logic [23:0] dn_time;
    logic        dn_wrap, dn_done;
    logic [7:0]  dn_com, dn_data;

    int n_checks = 0;
    int n_fail   = 0;

    // expected entry: {time[23:0], wrap, done, seg_com[7:0], seg_data[7:0]}
    logic [41:0] exp_q0[$];
    logic [41:0] exp_q1[$];

    time_counter_display #(.CLK_HZ_DIV(DIV), .SCAN_DIV(1), .N_DIGITS(4), .COUNT_DOWN(0)) dut_up (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .load(load),
        .load_bcd(load_bcd[15:0]), .time_bcd(up_time), .wrap(up_wrap),
        .done(up_done), .seg_com(up_com), .seg_data(up_data)
    );

    time_counter_display #(.CLK_HZ_DIV(DIV), .SCAN_DIV(1), .N_DIGITS(6), .COUNT_DOWN(1)) dut_dn (
        .clk(clk), .rst(rst), .run(run), .clear(clear), .load(load),
        .load_bcd(load_bcd), .time_bcd(dn_time), .wrap(dn_wrap),
        .done(dn_done), .seg_com(dn_com), .seg_data(dn_data)
    );

    // ------------------------------------------------------- clock and reset
    initial forever #5 clk = ~clk;

    // ------------------------------------------------------- check helper
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    int         ndig[2]   = '{4, 6};
    bit         is_down[2] = '{1'b0, 1'b1};
    int         m_sec[2];
    int         m_pre[2];
    int         m_idx[2];
    logic       m_wrap[2];
    logic       m_done[2];
    logic [7:0] seg_tab[10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                8'hB6, 8'hBE, 8'hE4, 8'hFE, 8'hF6};

    function automatic logic [23:0] sec_to_bcd(input int s);
        int h, m, ss;
        h  = s / 3600;
        m  = (s / 60) % 60;
        ss = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int bcd_to_sec(input logic [23:0] b, input int n);
        int s;
        s = int'(b[3:0]) + 10 * int'(b[7:4]) + 60 * (int'(b[11:8]) + 10 * int'(b[15:12]));
        if (n == 6)
            s += 3600 * (int'(b[19:16]) + 10 * int'(b[23:20]));
        return s;
    endfunction

    task automatic model_reset(input int i);
        m_sec[i] = 0; m_pre[i] = 0; m_idx[i] = 0; m_wrap[i] = 1'b0; m_done[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        int          old_s, old_i, period;
        bit          tick;
        logic [23:0] ob;
        logic [3:0]  dig;
        logic [7:0]  com, dat;
        logic [41:0] e;
        period = (ndig[i] == 6) ? 86400 : 3600;
        old_s = m_sec[i];
        old_i = m_idx[i];
        tick  = run && (m_pre[i] == DIV - 1);
        m_wrap[i] = 1'b0;
        if (clear) begin
            m_sec[i] = 0; m_pre[i] = 0;
        end else if (load) begin
            m_sec[i] = bcd_to_sec(load_bcd, ndig[i]); m_pre[i] = 0;
        end else if (run) begin
            m_pre[i] = tick ? 0 : m_pre[i] + 1;
            if (tick) begin
                if (is_down[i]) begin
                    if (m_sec[i] > 0) m_sec[i]--;
                end else begin
                    m_sec[i] = (m_sec[i] + 1) % period;
                    m_wrap[i] = (m_sec[i] == 0);
                end
            end
        end
        m_done[i] = is_down[i] && (m_sec[i] == 0);
        ob  = sec_to_bcd(old_s);
        dig = ob[4*old_i +: 4];
        com = 8'hFF;
        com[7 - old_i] = 1'b0;
        dat = seg_tab[dig] | ((old_i == 2 || old_i == 4) ? 8'h01 : 8'h00);
        m_idx[i] = (old_i + 1) % ndig[i];
        e = {sec_to_bcd(m_sec[i]), m_wrap[i], m_done[i], com, dat};
        if (i == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_edge(i);
        end
    end

    // ------------------------------------------------------- monitor / scoreboard
    logic [41:0] e0, e1;
    always @(negedge clk) begin
        if (exp_q0.size() > 0) begin
            e0 = exp_q0.pop_front();
            check("up_time", {16'h0, up_time}, {8'h0, e0[41:18]});
            check("up_wrap", {31'h0, up_wrap}, {31'h0, e0[17]});
            check("up_done", {31'h0, up_done}, {31'h0, e0[16]});
            check("up_seg_com", {24'h0, up_com}, {24'h0, e0[15:8]});
            check("up_seg_data", {24'h0, up_data}, {24'h0, e0[7:0]});
        end
        if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            check("dn_time", {8'h0, dn_time}, {8'h0, e1[41:18]});
            check("dn_wrap", {31'h0, dn_wrap}, {31'h0, e1[17]});
            check("dn_done", {31'h0, dn_done}, {31'h0, e1[16]});
            check("dn_seg_com", {24'h0, dn_com}, {24'h0, e1[15:8]});
            check("dn_seg_data", {24'h0, dn_data}, {24'h0, e1[7:0]});
        end
    end

    // ------------------------------------------------------- driver tasks
    task automatic step(input logic r, input logic c, input logic l, input logic [23:0] b);
        run = r; clear = c; load = l; load_bcd = b;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic r);
        for (int k = 0; k < n; k++) step(r, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_up_time"}, {16'h0, up_time}, 32'h0);
        check({tag, "_up_wrap"}, {31'h0, up_wrap}, 32'h0);
        check({tag, "_up_done"}, {31'h0, up_done}, 32'h0);
        check({tag, "_up_com"},  {24'h0, up_com},  32'hFF);
        check({tag, "_up_data"}, {24'h0, up_data}, 32'h00);
        check({tag, "_dn_time"}, {8'h0, dn_time},  32'h0);
        check({tag, "_dn_done"}, {31'h0, dn_done}, 32'h0);
        check({tag, "_dn_com"},  {24'h0, dn_com},  32'hFF);
        check({tag, "_dn_data"}, {24'h0, dn_data}, 32'h00);
    endtask

    function automatic logic [23:0] rand_time();
        int h, m, s;
        case ($urandom_range(0, 3))
            0: begin h = 23; m = 59; s = $urandom_range(55, 59); end
            1: begin h = $urandom_range(0, 23); m = 59; s = $urandom_range(56, 59); end
            2: begin h = 0; m = 0; s = $urandom_range(0, 5); end
            default: begin h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59); end
        endcase
        return sec_to_bcd(h * 3600 + m * 60 + s);
    endfunction

    // ------------------------------------------------------- main sequence
    initial begin
        #1 rst = 1'b1;
        #1 check_reset_values("reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;

        // Free-running count from reset.
        steps(4, 1'b1);
        check("first_second", {16'h0, up_time}, 32'h0001);
        steps(236, 1'b1);
        check("one_minute", {16'h0, up_time}, 32'h0100);
        check("dn_idle_done", {31'h0, dn_done}, 32'h1);

        // Rollover 59:59 -> 00:00 with a single-cycle wrap.
        step(1'b0, 1'b0, 1'b1, 24'h005959);
        steps(4, 1'b1);
        check("wrap_time", {16'h0, up_time}, 32'h0000);
        check("wrap_pulse", {31'h0, up_wrap}, 32'h1);
        steps(1, 1'b1);
        check("wrap_gone", {31'h0, up_wrap}, 32'h0);

        // Pause with the prescaler at 2; resume increments two clocks later.
        step(1'b0, 1'b1, 1'b0, 24'h0);
        steps(2, 1'b1);
        steps(10, 1'b0);
        check("paused_time", {16'h0, up_time}, 32'h0000);
        steps(1, 1'b1);
        check("resume_1clk", {16'h0, up_time}, 32'h0000);
        steps(1, 1'b1);
        check("resume_2clk", {16'h0, up_time}, 32'h0001);

        // Scan of a loaded value with time frozen.
        step(1'b0, 1'b0, 1'b1, 24'h001234);
        steps(8, 1'b0);

        // Timer runs down to zero and stops; a non-zero load releases done.
        step(1'b0, 1'b0, 1'b1, 24'h000003);
        steps(12, 1'b1);
        check("timer_zero", {8'h0, dn_time}, 32'h0);
        check("timer_done", {31'h0, dn_done}, 32'h1);
        steps(8, 1'b1);
        check("timer_stays", {8'h0, dn_time}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 24'h000010);
        check("timer_reload", {31'h0, dn_done}, 32'h0);

        // Clear, load and tick on the same edge: clear wins.
        step(1'b0, 1'b1, 1'b0, 24'h0);
        steps(3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 24'h001111);
        check("clr_ld_tick_up", {16'h0, up_time}, 32'h0);
        check("clr_ld_tick_dn", {8'h0, dn_time}, 32'h0);

        // Asynchronous reset in the middle of a cycle.
        step(1'b0, 1'b0, 1'b1, 24'h125847);
        steps(6, 1'b1);
        @(negedge clk); #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 39) == 0, rand_time());
        end
        steps(2, 1'b0);

        @(negedge clk); #1;
        check("q0_drained", exp_q0.size(), 32'h0);
        check("q1_drained", exp_q1.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
